// File: rtl/sound_pkg.sv
// ============================================================================
// Module : sound_pkg
// Brief  : Clip IDs, scheduler FSM states and sample-ROM clip address map.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sound_pkg;

  typedef enum logic [1:0] {
    WIN    = 2'd0,
    MOO    = 2'd1,
    DETECT = 2'd2,
    CHEER  = 2'd3
  } clip_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_e;

  localparam logic [17:0] c_win_start    = 18'd0;
  localparam logic [17:0] c_win_end      = 18'd16395;
  localparam logic [17:0] c_moo_start    = 18'd16396;
  localparam logic [17:0] c_moo_end      = 18'd66982;
  localparam logic [17:0] c_detect_start = 18'd66983;
  localparam logic [17:0] c_detect_end   = 18'd83254;
  localparam logic [17:0] c_cheer_start  = 18'd83255;
  localparam logic [17:0] c_cheer_end    = 18'd137138;

  function automatic logic [17:0] clip_start(input clip_e id);
    case (id)
      WIN:     return c_win_start;
      MOO:     return c_moo_start;
      DETECT:  return c_detect_start;
      default: return c_cheer_start;
    endcase
  endfunction

  function automatic logic [17:0] clip_end(input clip_e id);
    case (id)
      WIN:     return c_win_end;
      MOO:     return c_moo_end;
      DETECT:  return c_detect_end;
      default: return c_cheer_end;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sound_prio_arb.sv
// ============================================================================
// Module : sound_prio_arb
// Brief  : Pending clip-request register with fixed-priority grant (win first).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_prio_arb
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_req,
  input  logic       i_stop,
  input  logic       i_take,
  output logic       o_valid,
  output clip_e      o_grant
);

  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] grant_mask;

  always_comb begin
    o_grant    = WIN;
    grant_mask = 4'b0000;
    if (pending_q[0]) begin
      o_grant    = WIN;
      grant_mask = 4'b0001;
    end else if (pending_q[1]) begin
      o_grant    = MOO;
      grant_mask = 4'b0010;
    end else if (pending_q[2]) begin
      o_grant    = DETECT;
      grant_mask = 4'b0100;
    end else if (pending_q[3]) begin
      o_grant    = CHEER;
      grant_mask = 4'b1000;
    end
    o_valid = |pending_q;

    // New requests are OR-ed in after the grant clears its bit, so a request
    // landing on its own grant cycle survives and replays the clip.
    if (i_stop) begin
      pending_d = 4'b0000;
    end else begin
      pending_d = (pending_q & ~(i_take ? grant_mask : 4'b0000)) | i_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 4'b0000;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sound_scheduler.sv
// ============================================================================
// Module : sound_scheduler
// Brief  : Plays one sample-ROM clip at a time into the codec at a fixed rate.
//          Optional macro SOUND_SCHEDULER_LOOP_EN adds a 'loop' input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_scheduler
  import sound_pkg::*;
#(
  parameter int SAMPLE_DIV = 1200
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        stop,
  input  logic        audio_out_allowed,
  input  logic [5:0]  rom_q,
  output logic [17:0] rom_addr,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic        busy,
  output logic [1:0]  clip_id,
  output logic        clip_done
`ifdef SOUND_SCHEDULER_LOOP_EN
  ,
  input  logic        loop
`endif
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SAMPLE_DIV - 1);

  state_e            state_q, state_d;
  clip_e             clip_q, clip_d;
  logic [17:0]       rom_addr_q, rom_addr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [31:0]       left_q, left_d;
  logic              write_q, write_d;
  logic              done_q, done_d;
  logic              take;
  logic              grant_valid;
  clip_e             grant_id;

  sound_prio_arb u_arb (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_req   (req),
    .i_stop  (stop),
    .i_take  (take),
    .o_valid (grant_valid),
    .o_grant (grant_id)
  );

  always_comb begin
    state_d    = state_q;
    clip_d     = clip_q;
    rom_addr_d = rom_addr_q;
    div_d      = div_q;
    left_d     = left_q;
    write_d    = 1'b0;
    done_d     = 1'b0;
    take       = 1'b0;

    if (stop) begin
      state_d = IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            take    = 1'b1;
            clip_d  = grant_id;
            state_d = LOAD;
          end
        end
        LOAD: begin
          rom_addr_d = clip_start(clip_q);
          div_d      = '0;
          state_d    = WAIT;
        end
        WAIT: begin
          if (div_q == c_div_last) begin
            state_d = ISSUE;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ISSUE: begin
          if (audio_out_allowed) begin
            write_d = 1'b1;
            left_d  = {rom_q, 26'b0};
            // End check before increment keeps the address inside the clip.
            if (rom_addr_q == clip_end(clip_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
`ifdef SOUND_SCHEDULER_LOOP_EN
              if (loop) begin
                rom_addr_d = clip_start(clip_q);
                div_d      = '0;
                state_d    = WAIT;
              end
`endif
            end else begin
              rom_addr_d = rom_addr_q + 18'd1;
              div_d      = '0;
              state_d    = WAIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      clip_q     <= WIN;
      rom_addr_q <= 18'd0;
      div_q      <= '0;
      left_q     <= 32'd0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clip_q     <= clip_d;
      rom_addr_q <= rom_addr_d;
      div_q      <= div_d;
      left_q     <= left_d;
      write_q    <= write_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr               = rom_addr_q;
  assign write_audio_out        = write_q;
  assign left_channel_audio_out = left_q;
  assign busy                   = (state_q != IDLE);
  assign clip_id                = clip_q;
  assign clip_done              = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_scheduler.sv
// ============================================================================
// Module : tb_sound_scheduler
// Brief  : Self-checking bench for sound_scheduler with a behavioural ROM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sound_scheduler;

  localparam int DIV = 2;
  localparam logic [17:0] WIN_END = 18'd16395;
  localparam logic [17:0] MOO_S   = 18'd16396;
  localparam logic [17:0] DET_S   = 18'd66983;
  localparam logic [17:0] CH_S    = 18'd83255;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        stop;
  logic        audio_out_allowed;
  logic [5:0]  rom_q;
  logic [17:0] rom_addr;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic        busy;
  logic [1:0]  clip_id;
  logic        clip_done;
`ifdef SOUND_SCHEDULER_LOOP_EN
  logic        loop = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  id;
    logic [17:0] start;
  } vec_t;
  vec_t vecs[8];

  sound_scheduler #(.SAMPLE_DIV(DIV)) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .req                    (req),
    .stop                   (stop),
    .audio_out_allowed      (audio_out_allowed),
    .rom_q                  (rom_q),
    .rom_addr               (rom_addr),
    .write_audio_out        (write_audio_out),
    .left_channel_audio_out (left_channel_audio_out),
    .busy                   (busy),
    .clip_id                (clip_id),
    .clip_done              (clip_done)
`ifdef SOUND_SCHEDULER_LOOP_EN
    ,
    .loop                   (loop)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [5:0] rom_fn(input logic [17:0] a);
    return a[5:0] ^ a[11:6] ^ a[17:12];
  endfunction

  // Sample ROM with one cycle of read latency.
  always @(posedge CLOCK_50) rom_q <= rom_fn(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int eligible;
    int nstrobes;
    int cnt;
    int moved;
    int guard;
    logic [17:0] exp_addr;
    logic [17:0] held;
    logic [31:0] left_before;
    bit hs;
    bit last;
    bit done_seen;

    vecs[0] = '{4'b0001, 2'd0, 18'd0};
    vecs[1] = '{4'b0010, 2'd1, MOO_S};
    vecs[2] = '{4'b0100, 2'd2, DET_S};
    vecs[3] = '{4'b1000, 2'd3, CH_S};
    vecs[4] = '{4'b1010, 2'd1, MOO_S};
    vecs[5] = '{4'b1100, 2'd2, DET_S};
    vecs[6] = '{4'b1111, 2'd0, 18'd0};
    vecs[7] = '{4'b0110, 2'd1, MOO_S};

    reset = 1'b1; req = 4'b0; stop = 1'b0; audio_out_allowed = 1'b1;
    step(); step();
    check("rst_addr",  rom_addr, 0);
    check("rst_busy",  busy, 0);
    check("rst_write", write_audio_out, 0);
    check("rst_done",  clip_done, 0);
    check("rst_id",    clip_id, 0);
    check("rst_left",  left_channel_audio_out, 0);
    reset = 1'b0;
    step();

    // Grant priority and start address; stop then flushes what is left pending.
    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req; step(); req = 4'b0;
      step();
      check("tbl_busy", busy, 1);
      check("tbl_id", clip_id, vecs[i].id);
      step();
      check("tbl_start", rom_addr, vecs[i].start);
      stop = 1'b1; step(); stop = 1'b0;
      check("tbl_stop_busy", busy, 0);
      check("tbl_stop_done", clip_done, 0);
      cnt = 0;
      repeat (6) begin step(); if (busy) cnt++; end
      check("tbl_pending_cleared", cnt, 0);
    end

    // Full win clip with random back-pressure against a cycle-level timing model.
    req = 4'b0001; step(); req = 4'b0; step();
    c = 0; eligible = DIV + 1; exp_addr = 18'd0; done_seen = 0; nstrobes = 0;
    while (!done_seen && c < 90000) begin
      audio_out_allowed = ($urandom_range(7) != 0);
      if (c == 1000) req = 4'b0100;
      hs = (c >= eligible) && audio_out_allowed;
      step(); c++; req = 4'b0;
      check("win_strobe", write_audio_out, hs);
      last = 0;
      if (hs) begin
        nstrobes++;
        check("win_data", left_channel_audio_out, {rom_fn(exp_addr), 26'b0});
        if (exp_addr == WIN_END) begin
          last = 1; done_seen = 1;
        end else begin
          exp_addr = exp_addr + 18'd1;
        end
        eligible = c + DIV;
      end
      check("win_done", clip_done, last);
      check("win_addr", rom_addr, exp_addr);
      check("win_busy", busy, !done_seen);
    end
    check("win_finished", done_seen, 1);
    check("win_strobe_count", nstrobes, 16396);

    // Queued detect follows after a single idle cycle.
    audio_out_allowed = 1'b1;
    step();
    check("next_busy", busy, 1);
    check("next_id", clip_id, 2);
    step();
    check("next_start", rom_addr, DET_S);

    req = 4'b0001; step(); req = 4'b0;
    repeat (7) step();

    audio_out_allowed = 1'b0;
    held = rom_addr; cnt = 0; moved = 0;
    repeat (20) begin
      step();
      if (write_audio_out) cnt++;
      if (rom_addr != held) moved++;
    end
    check("bp_no_strobe", cnt, 0);
    check("bp_addr_frozen", moved, 0);
    audio_out_allowed = 1'b1;
    step();
    check("bp_release_strobe", write_audio_out, 1);
    check("bp_release_data", left_channel_audio_out, {rom_fn(held), 26'b0});
    check("bp_release_addr", rom_addr, held + 18'd1);

    guard = 0;
    while (rom_addr != 18'd70000 && guard < 20000) begin step(); guard++; end
    check("reach_70000", rom_addr, 70000);
    left_before = left_channel_audio_out;
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_done", clip_done, 0);
    check("stop_write", write_audio_out, 0);
    cnt = 0;
    repeat (10) begin step(); if (busy || clip_done || write_audio_out) cnt++; end
    check("stop_pending_cleared", cnt, 0);
    check("stop_left_kept", left_channel_audio_out, left_before);

    // Asynchronous reset in the middle of cheer.
    req = 4'b1000; step(); req = 4'b0;
    repeat (40) step();
    check("cheer_busy", busy, 1);
    check("cheer_id", clip_id, 3);
    #2 reset = 1'b1;
    #1;
    check("arst_addr",  rom_addr, 0);
    check("arst_busy",  busy, 0);
    check("arst_write", write_audio_out, 0);
    check("arst_done",  clip_done, 0);
    check("arst_id",    clip_id, 0);
    check("arst_left",  left_channel_audio_out, 0);
    step();
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin step(); if (busy || clip_done || write_audio_out) cnt++; end
    check("arst_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
